// File: rtl/remote_bus_arbiter.sv
// Round-robin arbiter that shares one remote device bus among NUM_CORES cores.
// One core owns the bus per grant; every other requester is stalled with ready low.
module remote_bus_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ID_WIDTH  = $clog2(NUM_CORES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CORES*16-1:0] core_addr,
  input  logic [NUM_CORES-1:0]    core_wren,
  input  logic [NUM_CORES-1:0]    core_rden,
  input  logic [NUM_CORES*16-1:0] core_write_val,
  output logic [NUM_CORES-1:0]    core_ready,
  output logic [15:0]             core_read_val,
  output logic [15:0]             mem_addr,
  output logic                    mem_wren,
  output logic                    mem_rden,
  output logic [15:0]             mem_write_val,
  input  logic                    mem_ready,
  input  logic [15:0]             mem_read_val,
  output logic                    grant_valid,
  output logic [ID_WIDTH-1:0]     grant_id
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]  owner_q, owner_d;
  logic [NUM_CORES-1:0] req;
  logic [ID_WIDTH:0]    pick;
  logic [15:0]          addr_arr  [NUM_CORES];
  logic [15:0]          wval_arr  [NUM_CORES];

  assign req = core_wren | core_rden;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
    assign addr_arr[i] = core_addr[16*i +: 16];
    assign wval_arr[i] = core_write_val[16*i +: 16];
  end

  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] id);
    return (id == ID_WIDTH'(NUM_CORES - 1)) ? '0 : id + 1'b1;
  endfunction

  // Returns {found, index}; scanning from the farthest offset back to the
  // pointer leaves the nearest requester as the final assignment.
  function automatic logic [ID_WIDTH:0] rr_pick(input logic [NUM_CORES-1:0] r,
                                                input logic [ID_WIDTH-1:0]  p);
    logic [ID_WIDTH:0] result;
    int idx;
    result = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= NUM_CORES) idx -= NUM_CORES;
      if (r[ID_WIDTH'(idx)]) result = {1'b1, ID_WIDTH'(idx)};
    end
    return result;
  endfunction

  assign pick = rr_pick(req, ptr_q);

  // NOTE: every output and next-state variable gets a default before the case,
  // so no path through the block leaves a value unassigned and no latch appears.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    core_ready    = '0;
    mem_addr      = '0;
    mem_wren      = 1'b0;
    mem_rden      = 1'b0;
    mem_write_val = '0;

    case (state_q)
      IDLE: begin
        if (pick[ID_WIDTH]) begin
          owner_d = pick[ID_WIDTH-1:0];
          state_d = BUSY;
        end
      end
      BUSY: begin
        mem_addr            = addr_arr[owner_q];
        mem_wren            = core_wren[owner_q];
        mem_rden            = core_rden[owner_q];
        mem_write_val       = wval_arr[owner_q];
        core_ready[owner_q] = mem_ready;
        if (!req[owner_q]) begin
          // Abandoned grant: fairness pointer is deliberately left where it was.
          state_d = IDLE;
        end else if (mem_ready) begin
          state_d = IDLE;
          ptr_d   = wrap_inc(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign grant_valid   = (state_q == BUSY);
  assign grant_id      = owner_q;
  assign core_read_val = mem_read_val;

`ifndef SYNTHESIS
  a_ready_onehot0 : assert property (@(posedge clk) disable iff (reset)
    $onehot0(core_ready));
  a_no_strobe_idle : assert property (@(posedge clk) disable iff (reset)
    !grant_valid |-> (!mem_wren && !mem_rden && core_ready == '0));
`endif

endmodule

// File: tb/tb_remote_bus_arbiter.sv
// Self-checking bench for remote_bus_arbiter: directed scenarios plus a
// randomized run compared against a cycle-level reference model.
module tb_remote_bus_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N*16-1:0]   core_addr, core_write_val;
  logic [N-1:0]      core_wren, core_rden, core_ready;
  logic [15:0]       core_read_val, mem_addr, mem_write_val, mem_read_val;
  logic              mem_wren, mem_rden, mem_ready, grant_valid;
  logic [IDW-1:0]    grant_id;

  logic [15:0]       a_addr [N];
  logic [15:0]       a_wval [N];
  logic [N-1:0]      a_wren, a_rden;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign core_addr[16*i +: 16]      = a_addr[i];
    assign core_write_val[16*i +: 16] = a_wval[i];
  end
  assign core_wren = a_wren;
  assign core_rden = a_rden;

  remote_bus_arbiter #(.NUM_CORES(N)) dut (
    .clk(clk), .reset(reset),
    .core_addr(core_addr), .core_wren(core_wren), .core_rden(core_rden),
    .core_write_val(core_write_val), .core_ready(core_ready),
    .core_read_val(core_read_val), .mem_addr(mem_addr), .mem_wren(mem_wren),
    .mem_rden(mem_rden), .mem_write_val(mem_write_val), .mem_ready(mem_ready),
    .mem_read_val(mem_read_val), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      a_addr[i] = '0;
      a_wval[i] = '0;
    end
    a_wren       = '0;
    a_rden       = '0;
    mem_ready    = 1'b0;
    mem_read_val = '0;
  endtask

  // Leaves the bench 1 time unit after a rising edge: the start of "cycle 0".
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    a_wren[0] = 1'b1;
    a_addr[0] = 16'h4000;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({grant_valid, grant_id, core_ready, mem_wren, mem_rden} !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %h expected 000", {grant_valid, grant_id, core_ready, mem_wren, mem_rden});
    end
    n_checks++;
    if ({mem_addr, mem_write_val} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 00000000", {mem_addr, mem_write_val});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single_read();
    do_reset();
    a_rden[2] = 1'b1;
    a_addr[2] = 16'h4010;
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_c0_idle: got %b expected 0", grant_valid);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({mem_wren, mem_rden, mem_addr} !== {1'b0, 1'b1, 16'h4010}) begin
      n_fail++;
      $display("FAIL single_c1_bus: got %h expected 14010", {mem_wren, mem_rden, mem_addr});
    end
    n_checks++;
    if ({grant_valid, grant_id, core_ready} !== {1'b1, 2'd2, 4'b0100}) begin
      n_fail++;
      $display("FAIL single_c1_ready: got %b expected 1100100", {grant_valid, grant_id, core_ready});
    end
    next_cycle();
    a_rden[2]    = 1'b0;
    mem_read_val = 16'hBEEF;
    @(negedge clk);
    n_checks++;
    if ({grant_valid, core_read_val} !== {1'b0, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL single_c2_data: got %h expected 0beef", {grant_valid, core_read_val});
    end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int exp_order [6] = '{0, 1, 3, 0, 1, 3};
    int g;
    logic [N-1:0] exp_ready;
    do_reset();
    for (int i = 0; i < N; i++) a_addr[i] = 16'h4000 + 16'(i);
    a_wren    = 4'b1011;
    mem_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (grant_valid !== (cyc % 2 == 1)) begin
        n_fail++;
        $display("FAIL rr_valid cycle %0d: got %b expected %b", cyc, grant_valid, (cyc % 2 == 1));
      end
      if (cyc % 2 == 1) begin
        g         = exp_order[cyc / 2];
        exp_ready = 4'b1 << g;
        n_checks++;
        if ({grant_id, core_ready, mem_addr} !== {IDW'(g), exp_ready, 16'h4000 + 16'(g)}) begin
          n_fail++;
          $display("FAIL rr_grant cycle %0d: got id=%0d ready=%b addr=%h expected id=%0d ready=%b",
                   cyc, grant_id, core_ready, mem_addr, g, exp_ready);
        end
      end else begin
        n_checks++;
        if (core_ready !== 4'b0) begin
          n_fail++;
          $display("FAIL rr_idle_ready cycle %0d: got %b expected 0000", cyc, core_ready);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_wait_states();
    do_reset();
    a_wren[1] = 1'b1;
    a_addr[1] = 16'h8000;
    a_wval[1] = 16'h1234;
    next_cycle();
    a_wren[0] = 1'b1;
    a_addr[0] = 16'hC000;
    a_wval[0] = 16'h5555;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      n_checks++;
      if ({grant_valid, grant_id, core_ready} !== {1'b1, 2'd1, 4'b0000}) begin
        n_fail++;
        $display("FAIL wait_stall %0d: got %b expected 1010000", cyc, {grant_valid, grant_id, core_ready});
      end
      n_checks++;
      if ({mem_wren, mem_rden, mem_addr, mem_write_val} !== {1'b1, 1'b0, 16'h8000, 16'h1234}) begin
        n_fail++;
        $display("FAIL wait_bus %0d: got %h expected 280001234", cyc, {mem_wren, mem_rden, mem_addr, mem_write_val});
      end
      next_cycle();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({grant_id, core_ready} !== {2'd1, 4'b0010}) begin
      n_fail++;
      $display("FAIL wait_complete: got %b expected 010010", {grant_id, core_ready});
    end
    next_cycle();
    a_wren[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_turnaround: got %b expected 0", grant_valid);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({grant_valid, grant_id, mem_addr} !== {1'b1, 2'd0, 16'hC000}) begin
      n_fail++;
      $display("FAIL wait_next_grant: got %h expected 4c000", {grant_valid, grant_id, mem_addr});
    end
    clear_inputs();
  endtask

  task automatic test_pointer_wrap();
    do_reset();
    a_wren[3] = 1'b1;
    a_addr[3] = 16'h4333;
    mem_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({grant_valid, grant_id} !== {1'b1, 2'd3}) begin
      n_fail++;
      $display("FAIL wrap_first: got %b expected 111", {grant_valid, grant_id});
    end
    next_cycle();
    a_wren[0] = 1'b1;
    a_addr[0] = 16'h4000;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({grant_valid, grant_id} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL wrap_grant: got %b expected 100", {grant_valid, grant_id});
    end
    clear_inputs();
  endtask

  task automatic test_abandon();
    do_reset();
    a_rden[2] = 1'b1;
    a_addr[2] = 16'h8222;
    next_cycle();
    a_rden[2] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({grant_valid, grant_id, core_ready, mem_rden} !== {1'b1, 2'd2, 4'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL abandon_busy: got %b expected 11000000", {grant_valid, grant_id, core_ready, mem_rden});
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abandon_idle: got %b expected 0", grant_valid);
    end
    a_rden[2] = 1'b1;
    a_rden[3] = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({grant_valid, grant_id} !== {1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL abandon_regrant: got %b expected 110", {grant_valid, grant_id});
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    a_wren[2] = 1'b1;
    mem_ready = 1'b1;
    next_cycle();
    next_cycle();
    a_wren[2] = 1'b0;
    mem_ready = 1'b0;
    a_wren[1] = 1'b1;
    a_addr[1] = 16'h4111;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({grant_valid, grant_id, mem_wren} !== {1'b1, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got %b expected 1011", {grant_valid, grant_id, mem_wren});
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (core_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL rst_mid_ready: got %b expected 0010", core_ready);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_wren, mem_rden, core_ready, grant_valid} !== 7'b0) begin
      n_fail++;
      $display("FAIL rst_mid_drop: got %b expected 0000000", {mem_wren, mem_rden, core_ready, grant_valid});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    a_wren[1] = 1'b1;
    a_wren[3] = 1'b1;
    a_addr[3] = 16'h4333;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({grant_valid, grant_id} !== {1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL rst_mid_regrant: got %b expected 101", {grant_valid, grant_id});
    end
    clear_inputs();
  endtask

  // Cores behave as the spec describes: raise a request, hold it stable until
  // ready is seen, occasionally abandon. The model tracks owner and pointer.
  task automatic test_random();
    bit           m_busy  = 1'b0;
    int           m_owner = 0;
    int           m_ptr   = 0;
    bit           pend [N];
    bit           done [N];
    logic [N-1:0] req_now, exp_ready;
    logic [1:0]   exp_strb;
    logic [31:0]  exp_data;
    int           r, c;
    do_reset();
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      done[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (done[i] || (pend[i] && $urandom_range(0, 19) == 0)) begin
          pend[i]   = 1'b0;
          a_wren[i] = 1'b0;
          a_rden[i] = 1'b0;
        end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]   = 1'b1;
          r         = int'($urandom_range(0, 7));
          a_wren[i] = (r == 0) || (r < 4);
          a_rden[i] = (r == 0) || (r >= 4);
          a_addr[i] = {2'($urandom_range(1, 3)), 14'($urandom)};
          a_wval[i] = 16'($urandom);
        end
      end
      mem_ready    = ($urandom_range(0, 2) != 0);
      mem_read_val = 16'($urandom);
      @(negedge clk);
      req_now   = a_wren | a_rden;
      exp_ready = (m_busy && mem_ready) ? (4'b1 << m_owner) : 4'b0;
      exp_strb  = m_busy ? {a_wren[m_owner], a_rden[m_owner]} : 2'b00;
      exp_data  = m_busy ? {a_addr[m_owner], a_wval[m_owner]} : 32'h0;
      n_checks++;
      if ({grant_valid, grant_id} !== {m_busy, IDW'(m_owner)}) begin
        n_fail++;
        $display("FAIL rand_grant cycle %0d: got %b expected %b", cyc, {grant_valid, grant_id}, {m_busy, IDW'(m_owner)});
      end
      n_checks++;
      if (core_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL rand_ready cycle %0d: got %b expected %b", cyc, core_ready, exp_ready);
      end
      n_checks++;
      if ({mem_wren, mem_rden} !== exp_strb) begin
        n_fail++;
        $display("FAIL rand_strobe cycle %0d: got %b expected %b", cyc, {mem_wren, mem_rden}, exp_strb);
      end
      n_checks++;
      if ({mem_addr, mem_write_val} !== exp_data) begin
        n_fail++;
        $display("FAIL rand_data cycle %0d: got %h expected %h", cyc, {mem_addr, mem_write_val}, exp_data);
      end
      n_checks++;
      if (core_read_val !== mem_read_val) begin
        n_fail++;
        $display("FAIL rand_rdata cycle %0d: got %h expected %h", cyc, core_read_val, mem_read_val);
      end
      for (int i = 0; i < N; i++) done[i] = core_ready[i] && req_now[i];
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (req_now[c]) begin
            m_owner = c;
            m_busy  = 1'b1;
            break;
          end
        end
      end else if (!req_now[m_owner]) begin
        m_busy = 1'b0;
      end else if (mem_ready) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N;
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_states();
    test_pointer_wrap();
    test_abandon();
    test_reset_mid_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
